// File: rtl/ray_packer_pkg.sv
// ray_packer_pkg: shared types and defaults for the ray packing stage.
// Contents: GPU word width and type, pixel coordinate width, default
// resolution and the 2-bit packer state encoding.
package ray_packer_pkg;
   localparam int GPU_WORD_W = 32;
   localparam int RAY_PIXEL_W = 16;
   localparam int RAY_RES_X = 320;
   localparam int RAY_RES_Y = 240;
   typedef logic [GPU_WORD_W-1:0] gpuWord_t;
   typedef enum logic [1:0] {
      S_X   = 2'd0,
      S_Y   = 2'd1,
      S_Z   = 2'd2,
      S_OUT = 2'd3
   } rayState_t;
endpackage

// File: rtl/ray_word_fifo.sv
// ray_word_fifo: synchronous first-word-fall-through FIFO.
// Ports: iClock/iReset (sync, active high), iFlush (sync empty),
//        iPush/iData write side, iPop/oData read side (oData is the head),
//        oFull, oEmpty, oCount (exact occupancy).
// A push while full is only accepted when a pop happens in the same cycle.
module ray_word_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     iClock,
   input  logic                     iReset,
   input  logic                     iFlush,
   input  logic                     iPush,
   input  logic [DATA_WIDTH-1:0]    iData,
   input  logic                     iPop,
   output logic [DATA_WIDTH-1:0]    oData,
   output logic                     oFull,
   output logic                     oEmpty,
   output logic [$clog2(DEPTH):0]   oCount
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_WIDTH-1:0] rMem [DEPTH];
   logic [AW-1:0] rRdPtr, rWrPtr;
   logic doRead, doWrite;
   assign oFull = oCount == (AW+1)'(DEPTH);
   assign oEmpty = oCount == '0;
   assign doRead = iPop && !oEmpty;
   assign doWrite = iPush && (!oFull || doRead);
   assign oData = rMem[rRdPtr];
   always_ff @(posedge iClock) begin
      if (doWrite) rMem[rWrPtr] <= iData;
   end
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge iClock) begin
      if (iReset || iFlush) begin
         rRdPtr <= '0;
         rWrPtr <= '0;
         oCount <= '0;
      end else begin
         if (doWrite) rWrPtr <= rWrPtr + 1'b1;
         if (doRead) rRdPtr <= rRdPtr + 1'b1;
         oCount <= oCount + (AW+1)'(doWrite) - (AW+1)'(doRead);
      end
   end
endmodule

// File: rtl/ray_packer.sv
// ray_packer: buffers the generation unit's word stream, groups every three
// words into an (X,Y,Z) ray vector, tags it with its pixel coordinate and
// offers it downstream over valid/ready. Flags dropped words.
// Ports: iClock, iReset (sync, active high), iEnable (low = abort/flush),
//        iFifoPush/iFifoData (word stream), oRayValid/iRayReady (handshake),
//        oRayX/Y/Z (vector), oPixelX/Y (tag), oFrameDone (pulse after last
//        pixel accepted), oOverflow (sticky) / iClearStatus, oFifoCount.
// Build option: define RAY_PACKER_PIXEL_TAG_EN to build the pixel counters
// and oFrameDone; otherwise those outputs are tied to 0.
module ray_packer
   import ray_packer_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int RES_X = RAY_RES_X,
   parameter int RES_Y = RAY_RES_Y
) (
   input  logic                          iClock,
   input  logic                          iReset,
   input  logic                          iEnable,
   input  logic                          iFifoPush,
   input  gpuWord_t                      iFifoData,
   output logic                          oRayValid,
   input  logic                          iRayReady,
   output gpuWord_t                      oRayX,
   output gpuWord_t                      oRayY,
   output gpuWord_t                      oRayZ,
   output logic [RAY_PIXEL_W-1:0]        oPixelX,
   output logic [RAY_PIXEL_W-1:0]        oPixelY,
   output logic                          oFrameDone,
   output logic                          oOverflow,
   input  logic                          iClearStatus,
   output logic [$clog2(FIFO_DEPTH):0]   oFifoCount
);
   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RES_X < 1 || RES_Y < 1) begin : gBadParam
      $error("ray_packer: FIFO_DEPTH must be a power of two >= 4 and RES_X/RES_Y positive");
   end
   rayState_t rState, rNext;
   gpuWord_t headWord;
   logic fifoFull, fifoEmpty, pop, accept, overflow;
   ray_word_fifo #(.DATA_WIDTH(GPU_WORD_W), .DEPTH(FIFO_DEPTH)) uFifo (
      .iClock (iClock),
      .iReset (iReset),
      .iFlush (!iEnable),
      .iPush  (iEnable && iFifoPush),
      .iData  (iFifoData),
      .iPop   (pop),
      .oData  (headWord),
      .oFull  (fifoFull),
      .oEmpty (fifoEmpty),
      .oCount (oFifoCount)
   );
   always_ff @(posedge iClock) begin
      rState <= (iReset || !iEnable) ? S_X : rNext;
   end
   always_comb begin
      rNext = (rState == S_OUT) ? (accept ? S_X : S_OUT)
            : (fifoEmpty ? rState : rayState_t'(rState + 2'd1));
   end
   // Gating with iEnable makes an abort drop oRayValid in the same cycle.
   always_comb begin
      pop = iEnable && rState != S_OUT && !fifoEmpty;
      accept = iEnable && rState == S_OUT && iRayReady;
      oRayValid = iEnable && rState == S_OUT;
      overflow = iEnable && iFifoPush && fifoFull && !pop;
   end
   always_ff @(posedge iClock) begin
      if (iReset) begin
         oRayX <= '0;
         oRayY <= '0;
         oRayZ <= '0;
         oOverflow <= 1'b0;
      end else begin
         if (pop && rState == S_X) oRayX <= headWord;
         if (pop && rState == S_Y) oRayY <= headWord;
         if (pop && rState == S_Z) oRayZ <= headWord;
         oOverflow <= overflow ? 1'b1 : iClearStatus ? 1'b0 : oOverflow;
      end
   end
`ifdef RAY_PACKER_PIXEL_TAG_EN
   logic lastX, lastY;
   assign lastX = oPixelX == RAY_PIXEL_W'(RES_X - 1);
   assign lastY = oPixelY == RAY_PIXEL_W'(RES_Y - 1);
   always_ff @(posedge iClock) begin
      if (iReset || !iEnable) begin
         oPixelX <= '0;
         oPixelY <= '0;
      end else if (accept) begin
         oPixelX <= lastX ? '0 : oPixelX + 1'b1;
         oPixelY <= lastX ? (lastY ? '0 : oPixelY + 1'b1) : oPixelY;
      end
      oFrameDone <= !iReset && accept && lastX && lastY;
   end
`else
   assign oPixelX = '0;
   assign oPixelY = '0;
   assign oFrameDone = 1'b0;
`endif
endmodule

// File: tb/tb_ray_packer.sv
// tb_ray_packer: self-checking bench for ray_packer against a queue-based
// reference model (word queue + list of captured components).
module tb_ray_packer;
   localparam int DEPTH = 8;
   localparam int RX = 4;
   localparam int RY = 2;
`ifdef RAY_PACKER_PIXEL_TAG_EN
   localparam bit TAG = 1'b1;
`else
   localparam bit TAG = 1'b0;
`endif
   logic iClock = 1'b0;
   logic iReset = 1'b1;
   logic iEnable = 1'b1;
   logic iFifoPush = 1'b0;
   logic [31:0] iFifoData = '0;
   logic iRayReady = 1'b0;
   logic iClearStatus = 1'b0;
   logic oRayValid, oFrameDone, oOverflow;
   logic [31:0] oRayX, oRayY, oRayZ;
   logic [15:0] oPixelX, oPixelY;
   logic [3:0] oFifoCount;
   int nChecks = 0;
   int nFails = 0;
   logic [31:0] q[$];
   logic [31:0] got[$];
   int px = 0, py = 0;
   bit ovf = 0, fdone = 0;
   int fdCount;
   always #5 iClock = ~iClock;
   ray_packer #(.FIFO_DEPTH(DEPTH), .RES_X(RX), .RES_Y(RY)) dut (
      .iClock(iClock), .iReset(iReset), .iEnable(iEnable),
      .iFifoPush(iFifoPush), .iFifoData(iFifoData),
      .oRayValid(oRayValid), .iRayReady(iRayReady),
      .oRayX(oRayX), .oRayY(oRayY), .oRayZ(oRayZ),
      .oPixelX(oPixelX), .oPixelY(oPixelY), .oFrameDone(oFrameDone),
      .oOverflow(oOverflow), .iClearStatus(iClearStatus), .oFifoCount(oFifoCount)
   );
   task automatic checkValue(string tag, logic [31:0] act, logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   // Reference: one clock edge of the packer, from the spec's rules.
   task automatic modelEdge(bit ena, bit push, logic [31:0] data, bit ready, bit clr);
      int n;
      bit popped, acc, setOvf;
      fdone = 0;
      if (!ena) begin
         q.delete();
         got.delete();
         px = 0;
         py = 0;
         if (clr) ovf = 0;
         return;
      end
      n = q.size();
      popped = 0;
      acc = 0;
      setOvf = 0;
      if (got.size() == 3) acc = ready;
      else if (n > 0) begin
         got.push_back(q.pop_front());
         popped = 1;
      end
      if (push) begin
         if (n < DEPTH || popped) q.push_back(data);
         else setOvf = 1;
      end
      if (setOvf) ovf = 1;
      else if (clr) ovf = 0;
      if (acc) begin
         got.delete();
         if (px == RX - 1) begin
            px = 0;
            if (py == RY - 1) begin
               py = 0;
               fdone = 1;
            end else py++;
         end else px++;
      end
   endtask
   task automatic compareAll();
      checkValue("count", 32'(oFifoCount), 32'(q.size()));
      checkValue("valid", 32'(oRayValid), 32'(got.size() == 3 && iEnable));
      checkValue("overflow", 32'(oOverflow), 32'(ovf));
      checkValue("frame_done", 32'(oFrameDone), 32'(TAG && fdone));
      if (got.size() == 3) begin
         checkValue("ray_x", oRayX, got[0]);
         checkValue("ray_y", oRayY, got[1]);
         checkValue("ray_z", oRayZ, got[2]);
         checkValue("pixel_x", 32'(oPixelX), TAG ? 32'(px) : 32'd0);
         checkValue("pixel_y", 32'(oPixelY), TAG ? 32'(py) : 32'd0);
      end
   endtask
   task automatic step(bit ena, bit push, logic [31:0] data, bit ready, bit clr);
      iEnable = ena;
      iFifoPush = push;
      iFifoData = data;
      iRayReady = ready;
      iClearStatus = clr;
      @(posedge iClock);
      modelEdge(ena, push, data, ready, clr);
      #1;
      compareAll();
      fdCount += int'(oFrameDone);
   endtask
   task automatic doReset();
      iReset = 1'b1;
      iEnable = 1'b1;
      iFifoPush = 1'b0;
      iRayReady = 1'b0;
      iClearStatus = 1'b0;
      @(posedge iClock);
      q.delete();
      got.delete();
      px = 0;
      py = 0;
      ovf = 0;
      fdone = 0;
      #1;
      iReset = 1'b0;
      checkValue("rst_valid", 32'(oRayValid), 32'd0);
      checkValue("rst_x", oRayX, 32'd0);
      checkValue("rst_y", oRayY, 32'd0);
      checkValue("rst_z", oRayZ, 32'd0);
      checkValue("rst_pix", {oPixelX, oPixelY}, 32'd0);
      checkValue("rst_flags", {30'd0, oFrameDone, oOverflow}, 32'd0);
      checkValue("rst_count", 32'(oFifoCount), 32'd0);
   endtask
   task automatic idle(int n, bit ready);
      for (int i = 0; i < n; i++) step(1, 0, 32'd0, ready, 0);
   endtask
   initial begin
      fdCount = 0;
      doReset();
      // Single ray, minimum latency, then second ray tag.
      step(1, 1, 32'h0001_0000, 1, 0);
      step(1, 1, 32'hFFFF_0000, 1, 0);
      step(1, 1, 32'h0000_8000, 1, 0);
      checkValue("lat_n1", 32'(oRayValid), 32'd0);
      idle(1, 1);
      checkValue("lat_n2", 32'(oRayValid), 32'd1);
      checkValue("single_x", oRayX, 32'h0001_0000);
      checkValue("single_y", oRayY, 32'hFFFF_0000);
      checkValue("single_z", oRayZ, 32'h0000_8000);
      checkValue("single_pix", {oPixelX, oPixelY}, 32'd0);
      idle(1, 1);
      for (int i = 0; i < 3; i++) step(1, 1, 32'h1234_0000 + 32'(i), 0, 0);
      idle(1, 0);
      checkValue("second_pix", {oPixelX, oPixelY}, TAG ? 32'h0001_0000 : 32'd0);
      idle(4, 1);
      // Back-pressure, overflow, clear, full with simultaneous pop.
      doReset();
      for (int i = 0; i < 11; i++) step(1, 1, 32'hB000_0000 + 32'(i), 0, 0);
      checkValue("bp_count", 32'(oFifoCount), 32'd8);
      checkValue("bp_noovf", 32'(oOverflow), 32'd0);
      step(1, 1, 32'hDEAD_BEEF, 0, 0);
      checkValue("ovf_count", 32'(oFifoCount), 32'd8);
      checkValue("ovf_set", 32'(oOverflow), 32'd1);
      step(1, 0, 32'd0, 0, 1);
      checkValue("ovf_clear", 32'(oOverflow), 32'd0);
      step(1, 0, 32'd0, 1, 0);
      step(1, 1, 32'hC000_0001, 0, 0);
      checkValue("full_pop_count", 32'(oFifoCount), 32'd8);
      checkValue("full_pop_ovf", 32'(oOverflow), 32'd0);
      idle(16, 1);
      // Frame wrap over RX*RY rays.
      doReset();
      fdCount = 0;
      for (int r = 0; r < RX * RY; r++)
         for (int w = 0; w < 3; w++) step(1, 1, 32'(r * 16 + w), 1, 0);
      idle(16, 1);
      checkValue("frame_pulses", 32'(fdCount), TAG ? 32'd1 : 32'd0);
      for (int w = 0; w < 3; w++) step(1, 1, 32'hF000_0000 + 32'(w), 0, 0);
      idle(2, 0);
      checkValue("wrap_valid", 32'(oRayValid), 32'd1);
      checkValue("wrap_pix", {oPixelX, oPixelY}, 32'd0);
      idle(2, 1);
      // Abort mid-ray.
      doReset();
      step(1, 1, 32'hAAAA_0001, 0, 0);
      step(1, 1, 32'hAAAA_0002, 0, 0);
      step(0, 1, 32'hAAAA_0003, 0, 0);
      checkValue("abort_count", 32'(oFifoCount), 32'd0);
      step(1, 1, 32'h5555_0001, 0, 0);
      step(1, 1, 32'h5555_0002, 0, 0);
      step(1, 1, 32'h5555_0003, 0, 0);
      idle(1, 0);
      checkValue("abort_x", oRayX, 32'h5555_0001);
      checkValue("abort_y", oRayY, 32'h5555_0002);
      checkValue("abort_z", oRayZ, 32'h5555_0003);
      step(0, 0, 32'd0, 0, 0);
      checkValue("abort_drop_valid", 32'(oRayValid), 32'd0);
      // Reset mid-ray.
      step(1, 1, 32'h7777_0001, 0, 0);
      step(1, 1, 32'h7777_0002, 0, 0);
      doReset();
      for (int w = 0; w < 3; w++) step(1, 1, 32'h8888_0000 + 32'(w), 0, 0);
      idle(2, 1);
      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, $urandom,
              $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end
endmodule
